// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle AND/OR/ADD/SUB/SLT/SRL plus an iterative shift-add MULTU.
// One result register with valid/ready on both sides; MULTU holds off new input while it iterates.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);
  localparam logic [5:0] OP_AND = 6'd36, OP_OR = 6'd37, OP_ADD = 6'd32, OP_SUB = 6'd34,
                         OP_SLT = 6'd42, OP_SRL = 6'd2, OP_MULTU = 6'd25;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d, ovf_q, ovf_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic               sub_op, add_c, add_v, accept;
  logic [WIDTH-1:0]   b_op, add_s;
  logic [2*WIDTH-1:0] acc_n;

  assign in_ready  = reset && (state_q == S_IDLE || (state_q == S_OUT && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_OUT);
  assign dataOut   = res_q;
  assign zero      = (res_q == '0);
  assign carry     = carry_q;
  assign overflow  = ovf_q;

  // Shared adder: SUB and SLT add ~B with carry-in 1.
  always_comb begin
    sub_op = (Signal == OP_SUB) || (Signal == OP_SLT);
    b_op   = sub_op ? ~dataB : dataB;
    {add_c, add_s} = {1'b0, dataA} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_op};
    add_v  = (dataA[WIDTH-1] == b_op[WIDTH-1]) && (add_s[WIDTH-1] != dataA[WIDTH-1]);
    acc_n  = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (accept) begin
      state_d = S_OUT;
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      unique case (Signal)
        OP_AND: res_d = dataA & dataB;
        OP_OR:  res_d = dataA | dataB;
        OP_ADD, OP_SUB: begin
          res_d   = add_s;
          carry_d = add_c;
          ovf_d   = add_v;
        end
        OP_SLT: res_d = {{(WIDTH-1){1'b0}}, add_s[WIDTH-1] ^ add_v};
        OP_SRL: res_d = dataA >> dataB[SHW-1:0];
        OP_MULTU: begin
          state_d  = S_BUSY;
          res_d    = res_q;
          mcand_d  = {{WIDTH{1'b0}}, dataA};
          mplier_d = dataB;
          acc_d    = '0;
          cnt_d    = '0;
        end
        default: res_d = '0;
      endcase
    end else if (state_q == S_OUT && out_ready) begin
      state_d = S_IDLE;
    end else if (state_q == S_BUSY) begin
      acc_d    = acc_n;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      // The last step's partial sum goes straight into the result register.
      if (cnt_q == SHW'(WIDTH-1)) begin
        state_d = S_OUT;
        res_d   = acc_n[WIDTH-1:0];
        carry_d = 1'b0;
        ovf_d   = |acc_n[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_alu_pipe;
  localparam logic [5:0] AND_ = 6'd36, OR_ = 6'd37, ADD_ = 6'd32, SUB_ = 6'd34,
                         SLT_ = 6'd42, SRL_ = 6'd2, MUL_ = 6'd25;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic iv, ir, ov, ordy, z, c, o;
  logic [31:0] a, b, dout;
  logic [5:0] op;
  logic iv8, ir8, ov8, ordy8, z8, c8, o8;
  logic [7:0] a8, b8, dout8;
  logic [5:0] op8;

  int n_chk = 0, n_err = 0;

  alu_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst_n), .in_valid(iv), .in_ready(ir), .dataA(a), .dataB(b),
    .Signal(op), .out_valid(ov), .out_ready(ordy), .dataOut(dout), .zero(z),
    .carry(c), .overflow(o));

  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst_n), .in_valid(iv8), .in_ready(ir8), .dataA(a8), .dataB(b8),
    .Signal(op8), .out_valid(ov8), .out_ready(ordy8), .dataOut(dout8), .zero(z8),
    .carry(c8), .overflow(o8));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic issue(input string tag, input logic [5:0] opc, input logic [31:0] va, vb);
    iv = 1'b1; op = opc; a = va; b = vb;
    chk({tag, "_in_ready"}, ir, 1);
    step;
    iv = 1'b0; a = 32'hdead_beef; b = 32'h1234_5678;
  endtask

  task automatic res(input string tag, input logic [31:0] d, input logic zz, cc, oo);
    chk({tag, "_valid"}, ov, 1);
    chk({tag, "_data"}, dout, d);
    chk({tag, "_zero"}, z, zz);
    chk({tag, "_carry"}, c, cc);
    chk({tag, "_ovf"}, o, oo);
  endtask

  task automatic mul(input string tag, input logic [31:0] va, vb, d, input logic zz, oo);
    int n;
    logic busy_rdy;
    issue(tag, MUL_, va, vb);
    n = 1; busy_rdy = 1'b0;
    while (!ov && n < 200) begin
      if (ir) busy_rdy = 1'b1;
      a = ~a;
      step;
      n++;
    end
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_busy_ready"}, busy_rdy, 0);
    res(tag, d, zz, 1'b0, oo);
  endtask

  task automatic issue8(input string tag, input logic [5:0] opc, input logic [7:0] va, vb);
    iv8 = 1'b1; op8 = opc; a8 = va; b8 = vb;
    chk({tag, "_in_ready"}, ir8, 1);
    step;
    iv8 = 1'b0; a8 = 8'h5a; b8 = 8'ha5;
  endtask

  task automatic res8(input string tag, input logic [7:0] d, input logic zz, cc, oo);
    chk({tag, "_valid"}, ov8, 1);
    chk({tag, "_data"}, dout8, d);
    chk({tag, "_zero"}, z8, zz);
    chk({tag, "_carry"}, c8, cc);
    chk({tag, "_ovf"}, o8, oo);
  endtask

  initial begin
    logic bad;
    int n;
    rst_n = 1'b0; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; op = '0;
    iv8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
    step; step;
    chk("rst_valid", ov, 0);
    chk("rst_data", dout, 0);
    chk("rst_zero", z, 1);
    chk("rst_carry", c, 0);
    chk("rst_ovf", o, 0);
    chk("rst_ready_low", ir, 0);
    chk("rst8_valid", ov8, 0);
    chk("rst8_zero", z8, 1);
    rst_n = 1'b1; #1;
    chk("rst_ready_high", ir, 1);

    issue("add_ovf", ADD_, 32'h7fff_ffff, 32'h1);
    res("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    issue("sub_eq", SUB_, 32'd5, 32'd5);
    res("sub_eq", 32'h0, 1'b1, 1'b1, 1'b0);
    issue("slt_neg", SLT_, 32'h8000_0000, 32'h1);
    res("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0);
    issue("slt_pos", SLT_, 32'h1, 32'h8000_0000);
    res("slt_pos", 32'h0, 1'b1, 1'b0, 1'b0);
    issue("add_wrap", ADD_, 32'hffff_ffff, 32'h1);
    res("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    issue("srl31", SRL_, 32'h8000_0000, 32'hffff_ffff);
    res("srl31", 32'h1, 1'b0, 1'b0, 1'b0);
    issue("and", AND_, 32'hf0f0, 32'hff00);
    res("and", 32'hf000, 1'b0, 1'b0, 1'b0);
    issue("or", OR_, 32'hf0f0, 32'h0f0f);
    res("or", 32'hffff, 1'b0, 1'b0, 1'b0);
    issue("bad_op", 6'd63, 32'h1234, 32'h5678);
    res("bad_op", 32'h0, 1'b1, 1'b0, 1'b0);

    mul("mul_big", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b1);
    mul("mul_7x6", 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);
    mul("mul_max", 32'hffff_ffff, 32'hffff_ffff, 32'h1, 1'b0, 1'b1);

    // Backpressure: result must hold while out_ready is low.
    step;
    chk("idle_valid", ov, 0);
    ordy = 1'b0;
    issue("bp_add", ADD_, 32'd3, 32'd4);
    iv = 1'b1; op = OR_; a = 32'h1; b = 32'h2;
    bad = 1'b0;
    repeat (5) begin
      if (dout !== 32'd7 || ov !== 1'b1 || ir !== 1'b0 || z !== 1'b0 || c !== 1'b0 || o !== 1'b0)
        bad = 1'b1;
      step;
    end
    chk("bp_hold", bad, 0);
    ordy = 1'b1; #1;
    chk("bp_release_ready", ir, 1);
    step;
    iv = 1'b0;
    res("bp_next_or", 32'h3, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a multiply discards it.
    issue("mul_abort", MUL_, 32'd7, 32'd6);
    repeat (10) step;
    rst_n = 1'b0;
    step;
    chk("abort_valid", ov, 0);
    chk("abort_data", dout, 0);
    chk("abort_zero", z, 1);
    chk("abort_ready_low", ir, 0);
    rst_n = 1'b1; #1;
    chk("abort_ready_high", ir, 1);
    bad = 1'b0;
    repeat (40) begin
      if (ov !== 1'b0) bad = 1'b1;
      step;
    end
    chk("abort_never_valid", bad, 0);

    // WIDTH = 8 instance
    issue8("w8_add", ADD_, 8'h7f, 8'h01);
    res8("w8_add", 8'h80, 1'b0, 1'b0, 1'b1);
    issue8("w8_slt", SLT_, 8'h80, 8'h01);
    res8("w8_slt", 8'h01, 1'b0, 1'b0, 1'b0);
    issue8("w8_srl", SRL_, 8'h80, 8'hff);
    res8("w8_srl", 8'h01, 1'b0, 1'b0, 1'b0);
    issue8("w8_mul", MUL_, 8'h10, 8'h10);
    n = 1;
    while (!ov8 && n < 100) begin
      step;
      n++;
    end
    chk("w8_mul_latency", n, 9);
    res8("w8_mul", 8'h00, 1'b1, 1'b0, 1'b1);
    issue8("w8_mul2", MUL_, 8'h0f, 8'h11);
    n = 1;
    while (!ov8 && n < 100) begin
      step;
      n++;
    end
    chk("w8_mul2_latency", n, 9);
    res8("w8_mul2", 8'hff, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 32-bit ripple-carry ALU. Performs AND/OR/ADD/SUB/SLT in one registered cycle and adds logical shift-right and an iterative unsigned multiply, with signed-correct SLT and zero/carry/overflow flags. Sits between the register-read and write-back stages of the multicycle datapath. Valid/ready on both sides provides backpressure while a multiply is in flight.

## Interface
- WIDTH, 32, datapath width. Must be a power of two, 4 or greater.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted when in_valid && in_ready at a rising edge.
- dataA  input  WIDTH  operand A.
- dataB  input  WIDTH  operand B. For SRL, dataB[SHW-1:0] is the shift amount.
- Signal  input  6  opcode: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result when out_valid && out_ready.
- dataOut  output  WIDTH  result.
- zero  output  1  dataOut == 0.
- carry  output  1  carry out of the MSB for ADD/SUB (SUB: 1 means no borrow). 0 for all other opcodes.
- overflow  output  1  signed overflow for ADD/SUB. Unsigned product overflow for MULTU. 0 otherwise.

## Operation
- FSM states:
  - IDLE: no result held.
  - BUSY: multiply iterating.
  - OUT: result held, out_valid = 1.
- in_ready = reset && (state == IDLE || (state == OUT && out_ready)). It is 0 in BUSY and whenever reset is low.
- Accept, single-cycle opcode: result and flags are computed from the operands and registered on the acceptance edge. Next state is OUT.
- Accept, MULTU: dataA, dataB and a 2*WIDTH accumulator (cleared) are loaded, iteration counter is set to 0, next state is BUSY.
- BUSY, each edge: if the multiplier LSB is 1, add the shifted multiplicand into the accumulator. Shift the multiplier right and the multiplicand left, then increment the counter.
  - When counter == WIDTH-1, that edge performs the final step and moves to OUT.
  - dataOut = accumulator[WIDTH-1:0]; overflow = |accumulator[2*WIDTH-1:WIDTH].
- OUT with out_ready = 1 and no new acceptance: go to IDLE. With a simultaneous acceptance, load the new operation directly (back-to-back).
- OUT with out_ready = 0: dataOut and all flags hold stable. No new acceptance.
- ADD/SUB/SLT share one WIDTH-bit adder. SUB and SLT use the inverted B operand with carry-in 1.
  - SLT result = {0, sum[WIDTH-1] ^ ovf}, i.e. a correct signed compare. Flags for SLT: carry = 0, overflow = 0.
- SRL: dataA >> dataB[SHW-1:0], zero-filled. Upper bits of dataB are ignored.
- Unknown opcode: accepted like a single-cycle op. dataOut = 0, zero = 1, carry = 0, overflow = 0.
- zero is always recomputed from the registered dataOut value and is valid whenever out_valid = 1.

## Timing
- Reset (reset low at an edge): state becomes IDLE; out_valid, dataOut, carry, overflow and counter become 0; zero becomes 1.
  - Reset during BUSY or OUT aborts the operation; the result is discarded and never presented.
  - in_ready is 0 for the cycle reset is low. Acceptance is possible from the first edge with reset high.
- Latency is counted in rising edges, acceptance edge inclusive:
  - Single-cycle ops: 1. out_valid is high in the cycle after acceptance.
  - MULTU: WIDTH+1.
- Throughput: one single-cycle op per clock when out_ready is held at 1. MULTU blocks for WIDTH+1 cycles.
- Inputs are sampled only on the acceptance edge. Operand changes afterwards have no effect.
- out_valid never drops without a completed handshake, except on reset.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 -> dataOut 0x80000000, overflow 1, carry 0, zero 0, out_valid one cycle after acceptance.
- SUB 5 - 5, then SLT A = 0x80000000, B = 0x00000001 back-to-back -> 0x0 (zero 1, carry 1), then 0x1. Both accepted on consecutive edges.
- SRL 0x80000000 by dataB = 0xFFFFFFFF (amount 31) -> 0x00000001. AND 0xF0F0 & 0xFF00 -> 0xF000. OR 0xF0F0 | 0x0F0F -> 0xFFFF. Opcode 63 -> 0, zero 1.
- MULTU 0x00010000 * 0x00010000 -> dataOut 0, zero 1, overflow 1, out_valid exactly 33 edges after acceptance; in_ready 0 throughout BUSY. MULTU 7 * 6 -> 42, overflow 0.
- Backpressure: hold out_ready = 0 for 5 cycles after an ADD result -> dataOut and flags stable, in_ready 0. Raise out_ready with in_valid high -> the next op is accepted on the same edge.
- Drive reset low at BUSY cycle 10 of a MULTU -> next cycle out_valid 0, dataOut 0, zero 1, in_ready 1 once reset is high. Repeat all cases with WIDTH = 8 (e.g. MULTU 0x10 * 0x10 -> 0, overflow 1, latency 9).
